uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel receive stage of the UART and the downstream counterpart of the transmitter top. It consumes a serial line, such as the transmitter's serial_data_tx in loopback or an external pin. It uses the same baud_sel and line_control_reg encoding as the transmitter. It oversamples at 16x, rebuilds the data frame and presents each received byte with a one-cycle valid strobe and per-frame error flags.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz.
OVERSAMPLE, 16, samples per bit; the mid-bit sample index is OVERSAMPLE/2-1 = 7.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
baud_sel  input  2  00=2400, 01=4800, 10=9600, 11=19200 baud.
line_control_reg  input  5  [1:0] data bits 00=5, 01=6, 10=7, 11=8; [2] stop bits 0=1, 1=2; [3] parity enable; [4] parity type 1=even, 0=odd.
serial_data_rx  input  1  serial line, idle high, asynchronous to clk.
data_output  output  8  received byte, LSB-aligned, unused upper bits 0.
data_valid  output  1  one-clk pulse when data_output and the error flags update.
parity_error  output  1  parity mismatch on the last frame.
framing_error  output  1  stop bit sampled low on the last frame.
active_flag  output  1  high while a frame is in reception.

Behaviour:
- Reset (rst=0, async):
  - all outputs 0.
  - synchronizer flops = 1.
  - FSM = IDLE; counters = 0.
- Synchronizer: 2-flop on serial_data_rx. All logic uses the second flop (rx_s).
- Tick generator: divisor DIV = CLK_HZ/(OVERSAMPLE*baud), integer truncated. One-clk tick each DIV clks. The counter is cleared on start detection to align phase.
- Sample counter: 0..15, advances on tick. A bit is sampled when the counter = 7 on a tick; the bit ends at 15.
- Latching: baud_sel and line_control_reg are latched on start detection. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE.
  - IDLE: on rx_s falling to 0, go to START; set active_flag=1.
  - START: at the mid sample, if rx_s=1 treat as a glitch, return to IDLE with active_flag=0 and no data_valid. Otherwise, at the end of the bit, go to DATA.
  - DATA:
    - shift in LSB first.
    - bit counter runs 0..N-1, with N = 5..8 from the latched LCR.
    - after the last bit go to PARITY if enabled, else STOP1.
  - PARITY: sample the bit. Expected bit = XOR(data) for even parity, ~XOR(data) for odd parity. A mismatch sets parity_err_int.
  - STOP1: at the mid sample, capture stop validity.
    - With 2 stop bits, continue to STOP2 (also checked at its mid sample); the frame completes at STOP2 mid.
    - Otherwise the frame completes here.
- Frame completion (the cycle after the completing mid sample):
  - data_output is loaded.
  - parity_error and framing_error are loaded (any stop sample low sets framing_error).
  - data_valid pulses for 1 clk; active_flag drops.
  - Go to IDLE if rx_s=1; else go to WAIT_IDLE.
- WAIT_IDLE (break or stuck-low line): stay until rx_s=1, then go to IDLE. No new start is detected meanwhile.
- Flag persistence: error flags and data_output hold until the next data_valid.
- Latency: data_valid follows the final stop-bit mid sample by 1 clk. That is about 2 clk of synchronizer delay plus about 8 ticks after the line's stop-bit start.
- Reset mid-frame: abort immediately, with no data_valid. The next start is detected only after rst=1 and a fresh falling edge.
- Start edge: a start edge arriving in the same cycle as frame completion is not lost. A falling rx_s in IDLE is detected regardless of when IDLE was entered.

Test Plan:
- Basic 8N1: CLK_HZ=1_843_200, baud_sel=10 (DIV=12), LCR=5'b00011; send 0xA5 → one data_valid, data_output=0xA5, both error flags 0. active_flag high from start edge to completion.
- 7E2: LCR=5'b11110; send 0x35 with parity bit 0 and two stop bits → data_output=0x35, parity_error=0. Repeat with parity bit 1 → parity_error=1, data_output=0x35.
- Framing/break: hold the line low for 20 bit times with LCR=8N1 → data_valid once, data_output=0x00, framing_error=1. No second frame until the line returns high; the next 0x5A frame is received cleanly with errors cleared.
- Glitch rejection: drive a 4-tick low pulse in IDLE → no data_valid, active_flag returns to 0 at the mid sample.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0xFF → outputs 0 at once, no data_valid. Then 0x81 after release is received correctly.
- Loopback: connect transmitter serial_data_tx to serial_data_rx, same baud_sel/LCR; sweep all 4 bauds and 5/6/7/8 data bits with random bytes → every byte is received masked to N bits, zero errors.

Source files
------------

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampling UART receive stage with parity and framing checks
// Serial line in, one byte per frame out with a single-cycle valid strobe.
module uart_receiver #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic [4:0] line_control_reg,
  input  logic       serial_data_rx,
  output logic [7:0] data_output,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       active_flag
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID_IDX  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(OVERSAMPLE - 1);
  localparam logic [15:0] DIV_2400  = 16'(CLK_HZ / (OVERSAMPLE * 2400));
  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (OVERSAMPLE * 4800));
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (OVERSAMPLE * 9600));
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (OVERSAMPLE * 19200));

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [15:0]   div_cnt_q, div_cnt_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [1:0]    baud_q, baud_d;
  logic [4:0]    lcr_q, lcr_d;
  logic          par_err_q, par_err_d;
  logic          stop_err_q, stop_err_d;
  logic [7:0]    data_output_q, data_output_d;
  logic          data_valid_q, data_valid_d;
  logic          parity_error_q, parity_error_d;
  logic          framing_error_q, framing_error_d;
  logic          active_q, active_d;

  logic [15:0] div_sel;
  logic        tick, mid, bit_end, complete, frame_ferr, par_exp;
  logic [7:0]  aligned;
  logic [2:0]  nbits_m1;

  always_comb begin
    case (baud_q)
      2'b00:   div_sel = DIV_2400;
      2'b01:   div_sel = DIV_4800;
      2'b10:   div_sel = DIV_9600;
      default: div_sel = DIV_19200;
    endcase
  end

  assign tick     = (div_cnt_q == div_sel - 16'd1);
  assign mid      = tick && (samp_cnt_q == MID_IDX);
  assign bit_end  = tick && (samp_cnt_q == LAST_IDX);
  assign nbits_m1 = {1'b1, lcr_q[1:0]};
  // Bits enter at the MSB, so a short word sits high and is shifted down by 8-N.
  assign aligned  = shreg_q >> (2'd3 - lcr_q[1:0]);
  assign par_exp  = lcr_q[4] ? (^aligned) : ~(^aligned);

  always_comb begin
    state_d         = state_q;
    div_cnt_d       = div_cnt_q;
    samp_cnt_d      = samp_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shreg_d         = shreg_q;
    baud_d          = baud_q;
    lcr_d           = lcr_q;
    par_err_d       = par_err_q;
    stop_err_d      = stop_err_q;
    data_output_d   = data_output_q;
    data_valid_d    = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    active_d        = active_q;
    complete        = 1'b0;
    frame_ferr      = 1'b0;

    if (state_q != IDLE) begin
      if (tick) begin
        div_cnt_d  = 16'd0;
        samp_cnt_d = (samp_cnt_q == LAST_IDX) ? '0 : samp_cnt_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        div_cnt_d  = 16'd0;
        samp_cnt_d = '0;
        if (!rx_s_q) begin
          state_d    = START;
          active_d   = 1'b1;
          baud_d     = baud_sel;
          lcr_d      = line_control_reg;
          bit_cnt_d  = 3'd0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      START: begin
        if (mid && rx_s_q) begin
          state_d  = IDLE;
          active_d = 1'b0;
        end else if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (mid) shreg_d = {rx_s_q, shreg_q[7:1]};
        if (bit_end) begin
          if (bit_cnt_q == nbits_m1) begin
            bit_cnt_d = 3'd0;
            state_d   = lcr_q[3] ? PARITY : STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (mid) par_err_d = (rx_s_q != par_exp);
        if (bit_end) state_d = STOP1;
      end
      STOP1: begin
        if (mid) begin
          if (lcr_q[2]) begin
            stop_err_d = ~rx_s_q;
          end else begin
            complete   = 1'b1;
            frame_ferr = ~rx_s_q;
          end
        end
        if (bit_end && lcr_q[2]) state_d = STOP2;
      end
      STOP2: begin
        if (mid) begin
          complete   = 1'b1;
          frame_ferr = stop_err_q | ~rx_s_q;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A low line at the completing sample is a break; hold off until it releases.
    if (complete) begin
      data_output_d   = aligned;
      parity_error_d  = par_err_q;
      framing_error_d = frame_ferr;
      data_valid_d    = 1'b1;
      active_d        = 1'b0;
      state_d         = rx_s_q ? IDLE : WAIT_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      div_cnt_q       <= 16'd0;
      samp_cnt_q      <= '0;
      bit_cnt_q       <= 3'd0;
      shreg_q         <= 8'd0;
      baud_q          <= 2'd0;
      lcr_q           <= 5'd0;
      par_err_q       <= 1'b0;
      stop_err_q      <= 1'b0;
      data_output_q   <= 8'd0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      active_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      rx_meta_q       <= serial_data_rx;
      rx_s_q          <= rx_meta_q;
      div_cnt_q       <= div_cnt_d;
      samp_cnt_q      <= samp_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shreg_q         <= shreg_d;
      baud_q          <= baud_d;
      lcr_q           <= lcr_d;
      par_err_q       <= par_err_d;
      stop_err_q      <= stop_err_d;
      data_output_q   <= data_output_d;
      data_valid_q    <= data_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      active_q        <= active_d;
    end
  end

  assign data_output   = data_output_q;
  assign data_valid    = data_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign active_flag   = active_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
// A bench-side serial driver builds frames; expected values are hand-computed.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] baud_sel = 2'b10;
  logic [4:0] line_control_reg = 5'b00011;
  logic       serial_data_rx = 1'b1;
  logic [7:0] data_output;
  logic       data_valid, parity_error, framing_error, active_flag;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  int act_cnt = 0;

  uart_receiver #(.CLK_HZ(1_843_200), .OVERSAMPLE(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .baud_sel         (baud_sel),
    .line_control_reg (line_control_reg),
    .serial_data_rx   (serial_data_rx),
    .data_output      (data_output),
    .data_valid       (data_valid),
    .parity_error     (parity_error),
    .framing_error    (framing_error),
    .active_flag      (active_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) vcnt++;
    if (active_flag) act_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int bclk);
    serial_data_rx = v;
    repeat (bclk) @(negedge clk);
  endtask

  // Called on a negedge; leaves the line idle high when done.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input bit par_bit, input int nstop, input int bclk);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < nbits; i++) drive_bit(d[i], bclk);
    if (par_en) drive_bit(par_bit, bclk);
    for (int i = 0; i < nstop; i++) drive_bit(1'b1, bclk);
    serial_data_rx = 1'b1;
  endtask

  int v0;
  int bclk_tab [4] = '{768, 384, 192, 96};
  logic [7:0] sweep_b [4] = '{8'h3C, 8'hE7, 8'h5B, 8'hC6};
  logic [7:0] d, mask;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data_output}, 32'h0);
    chk("rst_valid", {31'd0, data_valid}, 32'h0);
    chk("rst_perr", {31'd0, parity_error}, 32'h0);
    chk("rst_ferr", {31'd0, framing_error}, 32'h0);
    chk("rst_active", {31'd0, active_flag}, 32'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 0xA5 at 9600 (DIV=12, 192 clk per bit)
    v0 = vcnt; act_cnt = 0;
    fork
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 192);
      begin
        repeat (960) @(negedge clk);
        chk("8n1_active_mid", {31'd0, active_flag}, 32'h1);
      end
    join
    repeat (20) @(negedge clk);
    chk("8n1_vcnt", vcnt - v0, 1);
    chk("8n1_data", {24'd0, data_output}, 32'hA5);
    chk("8n1_perr", {31'd0, parity_error}, 32'h0);
    chk("8n1_ferr", {31'd0, framing_error}, 32'h0);
    chk("8n1_active_len", (act_cnt >= 1818 && act_cnt <= 1830) ? 32'd1 : 32'd0, 32'd1);

    // 7E2 0x35 (four ones -> even parity bit 0), then the wrong parity bit
    line_control_reg = 5'b11110;
    v0 = vcnt;
    send_frame(8'h35, 7, 1'b1, 1'b0, 2, 192);
    repeat (20) @(negedge clk);
    chk("7e2_vcnt", vcnt - v0, 1);
    chk("7e2_data", {24'd0, data_output}, 32'h35);
    chk("7e2_perr", {31'd0, parity_error}, 32'h0);
    chk("7e2_ferr", {31'd0, framing_error}, 32'h0);
    v0 = vcnt;
    send_frame(8'h35, 7, 1'b1, 1'b1, 2, 192);
    repeat (20) @(negedge clk);
    chk("7e2b_vcnt", vcnt - v0, 1);
    chk("7e2b_data", {24'd0, data_output}, 32'h35);
    chk("7e2b_perr", {31'd0, parity_error}, 32'h1);
    chk("7e2b_ferr", {31'd0, framing_error}, 32'h0);

    // Break: line low for 20 bit times, 8N1
    line_control_reg = 5'b00011;
    v0 = vcnt;
    drive_bit(1'b0, 20 * 192);
    chk("brk_vcnt", vcnt - v0, 1);
    chk("brk_data", {24'd0, data_output}, 32'h0);
    chk("brk_ferr", {31'd0, framing_error}, 32'h1);
    chk("brk_perr", {31'd0, parity_error}, 32'h0);
    chk("brk_active", {31'd0, active_flag}, 32'h0);
    drive_bit(1'b1, 192);
    chk("brk_release_vcnt", vcnt - v0, 1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 192);
    repeat (20) @(negedge clk);
    chk("brk_next_vcnt", vcnt - v0, 2);
    chk("brk_next_data", {24'd0, data_output}, 32'h5A);
    chk("brk_next_ferr", {31'd0, framing_error}, 32'h0);

    // Glitch: 4 ticks (48 clk) low in IDLE
    v0 = vcnt;
    serial_data_rx = 1'b0;
    repeat (40) @(negedge clk);
    chk("glitch_active_hi", {31'd0, active_flag}, 32'h1);
    repeat (8) @(negedge clk);
    serial_data_rx = 1'b1;
    repeat (82) @(negedge clk);
    chk("glitch_active_lo", {31'd0, active_flag}, 32'h0);
    repeat (300) @(negedge clk);
    chk("glitch_vcnt", vcnt - v0, 0);
    chk("glitch_data_hold", {24'd0, data_output}, 32'h5A);

    // Reset during DATA bit 3 of 0xFF
    v0 = vcnt;
    fork
      send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 192);
      begin
        repeat (864) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_data", {24'd0, data_output}, 32'h0);
        chk("rstmid_active", {31'd0, active_flag}, 32'h0);
        chk("rstmid_valid", {31'd0, data_valid}, 32'h0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    chk("rstmid_vcnt", vcnt - v0, 0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 192);
    repeat (20) @(negedge clk);
    chk("after_rst_vcnt", vcnt - v0, 1);
    chk("after_rst_data", {24'd0, data_output}, 32'h81);
    chk("after_rst_ferr", {31'd0, framing_error}, 32'h0);

    // Sweep all bauds and word lengths; odd parity on 4800 and 19200
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < 4; w++) begin
        baud_sel = 2'(b);
        line_control_reg = {1'b0, 1'(b % 2), 1'b0, 2'(w)};
        d = sweep_b[w] ^ {2'(b), 2'(b), 2'(b), 2'(b)};
        mask = 8'hFF >> (3 - w);
        v0 = vcnt;
        send_frame(d, 5 + w, (b % 2) == 1, ~(^(d & mask)), 1, bclk_tab[b]);
        repeat (20) @(negedge clk);
        chk($sformatf("sweep_b%0d_w%0d_vcnt", b, w), vcnt - v0, 1);
        chk($sformatf("sweep_b%0d_w%0d_data", b, w), {24'd0, data_output}, {24'd0, d & mask});
        chk($sformatf("sweep_b%0d_w%0d_err", b, w), {30'd0, parity_error, framing_error}, 32'h0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
